// File: rtl/serial_subtractor.sv
// Chunk-serial subtractor: diff = bits_a - bits_b - borrow_in, CHUNK bits per cycle,
// LSB chunk first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int BITWIDTH = 8,
  parameter int CHUNK    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] bits_a,
  input  logic [BITWIDTH-1:0] bits_b,
  input  logic                borrow_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int N     = BITWIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [BITWIDTH-1:0] a_sh;
  logic [BITWIDTH-1:0] b_sh;
  logic [BITWIDTH-1:0] diff_q;
  logic                a_msb;
  logic                b_msb;
  logic                borrow_q;
  logic                borrow_out_q;
  logic                overflow_q;

  logic [CHUNK:0]      chunk_sub;
  logic [BITWIDTH-1:0] diff_next;
  logic                last_chunk;

  // Operands shift right so the active chunk always sits in the low bits; result
  // chunks enter at the top so diff is LSB-aligned after the last chunk.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    chunk_sub = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, borrow_q};
    diff_next = (diff_q >> CHUNK)
              | (BITWIDTH'(chunk_sub[CHUNK-1:0]) << (BITWIDTH - CHUNK));
  end

  assign last_chunk = (cnt == CNT_W'(N - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are plain flops, not a memory,
      // so they all take a defined reset value.
      state        <= IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      diff_q       <= '0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= bits_a;
            b_sh     <= bits_b;
            a_msb    <= bits_a[BITWIDTH-1];
            b_msb    <= bits_b[BITWIDTH-1];
            borrow_q <= borrow_in;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> CHUNK;
          b_sh     <= b_sh >> CHUNK;
          diff_q   <= diff_next;
          borrow_q <= chunk_sub[CHUNK];
          if (last_chunk) begin
            cnt          <= '0;
            borrow_out_q <= chunk_sub[CHUNK];
            // Signed overflow only when operand signs differ and the result sign
            // departs from the minuend's.
            overflow_q   <= (a_msb ^ b_msb) & (diff_next[BITWIDTH-1] ^ a_msb);
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a directed 8-bit/CHUNK=1 instance plus
// several wider/chunked instances driven with random operands against a reference.
module tb_serial_subtractor;

  localparam int NCFG = 6;

  logic clk;
  logic rst_n;
  logic rst_g_n;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   gen_done = 0;

  function automatic int cfg_bw(input int i);
    case (i)
      0:       return 8;
      1:       return 8;
      2:       return 16;
      3:       return 32;
      4:       return 64;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_ck(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 4;
      3:       return 8;
      4:       return 16;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event within budget", name);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- directed 8-bit, CHUNK=1 instance ----------------
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  serial_subtractor #(.BITWIDTH(8), .CHUNK(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bits_a     (a),
    .bits_b     (b),
    .borrow_in  (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (bout),
    .overflow   (ovf)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         acc;
  } exp8_t;

  exp8_t q8[$];

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    int    t;
    exp8_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      fail_now("main in_ready");
      return;
    end
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.diff   = ed;
    e.bout   = eb;
    e.ovf    = eo;
    e.acc    = cyc;
    if (push) q8.push_back(e);
  endtask

  // Monitor: first DONE sample pops and compares; later DONE samples check stability.
  initial begin : mon8
    bit         seen;
    exp8_t      cur;
    logic [7:0] s_diff;
    logic       s_bout;
    logic       s_ovf;
    seen = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          seen   = 1;
          s_diff = diff;
          s_bout = bout;
          s_ovf  = ovf;
          if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL main unexpected_result: got diff %0h expected no result", diff);
          end else begin
            cur = q8.pop_front();
            check("main diff", diff, cur.diff);
            check("main borrow_out", bout, cur.bout);
            check("main overflow", ovf, cur.ovf);
            check("main latency", cyc - cur.acc, 8);
          end
        end else begin
          check("main stable diff", diff, s_diff);
          check("main stable borrow_out", bout, s_bout);
          check("main stable overflow", ovf, s_ovf);
        end
      end else begin
        seen = 0;
      end
    end
  end

  // ---------------- random wide / chunked instances ----------------
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int BW = cfg_bw(gi);
    localparam int CK = cfg_ck(gi);
    localparam int NN = BW / CK;

    typedef struct packed {
      logic [BW-1:0] diff;
      logic          bout;
      logic          ovf;
      int            acc;
    } expg_t;

    expg_t         gq[$];
    logic          g_in_valid;
    logic          g_in_ready;
    logic [BW-1:0] g_a;
    logic [BW-1:0] g_b;
    logic          g_bin;
    logic          g_out_valid;
    logic [BW-1:0] g_diff;
    logic          g_bout;
    logic          g_ovf;

    serial_subtractor #(.BITWIDTH(BW), .CHUNK(CK)) u_g (
      .clk        (clk),
      .rst_n      (rst_g_n),
      .in_valid   (g_in_valid),
      .in_ready   (g_in_ready),
      .bits_a     (g_a),
      .bits_b     (g_b),
      .borrow_in  (g_bin),
      .out_valid  (g_out_valid),
      .out_ready  (1'b1),
      .diff       (g_diff),
      .borrow_out (g_bout),
      .overflow   (g_ovf)
    );

    initial begin : stim
      int          t;
      logic [63:0] ra;
      logic [63:0] rb;
      logic [BW:0] full;
      expg_t       e;
      g_in_valid = 1'b0;
      g_a        = '0;
      g_b        = '0;
      g_bin      = 1'b0;
      wait (rst_g_n === 1'b1);
      for (int k = 0; k < 8; k++) begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        if (k == 0) begin
          ra = '0;
          rb = '0;
        end
        t = 0;
        @(negedge clk);
        while (!g_in_ready && t < 500) begin
          @(negedge clk);
          t++;
        end
        if (t >= 500) begin
          fail_now($sformatf("cfg%0d in_ready", gi));
          break;
        end
        g_a        = ra[BW-1:0];
        g_b        = rb[BW-1:0];
        g_bin      = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        full       = {1'b0, g_a} - {1'b0, g_b} - {{BW{1'b0}}, g_bin};
        e.diff     = full[BW-1:0];
        e.bout     = full[BW];
        e.ovf      = (g_a[BW-1] != g_b[BW-1]) && (full[BW-1] != g_a[BW-1]);
        g_in_valid = 1'b1;
        @(posedge clk);
        #1;
        g_in_valid = 1'b0;
        e.acc      = cyc;
        gq.push_back(e);
      end
      t = 0;
      while (gq.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) fail_now($sformatf("cfg%0d drain", gi));
      gen_done++;
    end

    initial begin : mon
      bit    seen;
      expg_t cur;
      seen = 0;
      forever begin
        @(negedge clk);
        if (g_out_valid && !seen) begin
          seen = 1;
          if (gq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d unexpected_result: got diff %0h expected no result", gi, g_diff);
          end else begin
            cur = gq.pop_front();
            check($sformatf("cfg%0d diff", gi), 64'(g_diff), 64'(cur.diff));
            check($sformatf("cfg%0d borrow_out", gi), g_bout, cur.bout);
            check($sformatf("cfg%0d overflow", gi), g_ovf, cur.ovf);
            check($sformatf("cfg%0d latency", gi), cyc - cur.acc, NN);
          end
        end else if (!g_out_valid) begin
          seen = 0;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main_seq
    int t;
    rst_n     = 1'b0;
    rst_g_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset diff", diff, 0);
    check("reset borrow_out", bout, 0);
    check("reset overflow", ovf, 0);
    rst_n   = 1'b1;
    rst_g_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle in_ready", in_ready, 1);
    out_ready = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
    do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);

    // Stall in DONE while offering new operands that must be ignored.
    do_op(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("stall out_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 8'hAA;
      b        = 8'h55;
      bin      = 1'b1;
      @(negedge clk);
      check("stall in_ready", in_ready, 0);
      check("stall out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("release in_ready", in_ready, 1);
    check("release out_valid", out_valid, 0);
    do_op(8'hC8, 8'h32, 1'b1, 8'h95, 1'b0, 1'b0, 1'b1);

    // Reset during the third RUN cycle discards the in-flight result.
    do_op(8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset out_valid", out_valid, 0);
    check("midrun_reset diff", diff, 0);
    check("midrun_reset borrow_out", bout, 0);
    check("midrun_reset overflow", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset in_ready", in_ready, 1);
    check("post_reset out_valid", out_valid, 0);
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);

    t = 0;
    while ((gen_done < NCFG || q8.size() != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_now("final drain");
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
